shot_load_ram: RTL
==================

# shot_load_ram

Parametrised successor to the 16×2 shot-load memory in the AstroGenius datapath. Holds one load counter per shot slot. Each entry can be written directly or adjusted in place with a saturating increment or decrement. A synchronous reset or an `init` request restores every entry to `INIT_VAL` through a one-entry-per-cycle sweep, so the design never relies on power-up `initial` contents.

## Interface
- `DATA_W`, default 2: width of each entry.
- `ADDR_W`, default 4: address width; depth = 2^ADDR_W.
- `INIT_VAL`, default 2'b10: value loaded into every entry by reset or `init`; must be ≤ `MAX_VAL`.
- `MAX_VAL`, default 2^DATA_W−1: saturation ceiling for `inc`.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high; starts the init sweep.
- `init` in 1: one-cycle request to re-run the sweep without a full reset.
- `we` in 1: write `data` to `addr`.
- `inc` in 1: saturating +1 on `ram[addr]`.
- `dec` in 1: saturating −1 on `ram[addr]`.
- `data` in DATA_W: write data.
- `addr` in ADDR_W: access address.
- `q` out DATA_W: registered-address read data.
- `zero` out 1: `q == 0`.
- `busy` out 1: sweep in progress; user ops ignored.
- `sat` out 1: registered one-cycle pulse; the last accepted `inc` or `dec` hit its limit.

## Operation
- FSM has two states, IDLE and SWEEP.
- Sweep pointer `ptr` is ADDR_W bits.
- `reset` high at an edge: state←SWEEP, `ptr`←0, `addr_reg`←0, `sat`←0.
  - Held high: `ram[0]` is rewritten each cycle and `ptr` stays 0.
- SWEEP: each cycle `ram[ptr]`←`INIT_VAL`, `ptr`←`ptr`+1.
  - When `ptr` = 2^ADDR_W−1 is written, state←IDLE.
  - No wrap past the top address.
- `init` in IDLE: same entry into SWEEP as `reset`, except `addr_reg` is not cleared. `init` during SWEEP is ignored.
- `busy` = (state == SWEEP), registered.
- While `busy`:
  - `we`, `inc`, `dec` are dropped; no effect and no `sat`.
  - `q` is forced to `INIT_VAL`.
- IDLE op priority is `we` > `dec` > `inc`; exactly one op is applied per cycle.
- Op arithmetic:
  - `dec`: value 0 stays 0 and sets `sat`; otherwise value−1.
  - `inc`: value `MAX_VAL` stays and sets `sat`; otherwise value+1.
  - Arithmetic uses DATA_W+1 bits internally; results never wrap.
- `addr_reg`←`addr` every IDLE cycle, whether or not an op is present. Read is `q = ram[addr_reg]` (asynchronous array read of the registered address).

## Timing
- Reset values:
  - `busy`=1 from the first edge with `reset` high.
  - `sat`=0.
  - `q`=`INIT_VAL` (forced).
  - `zero`=(`INIT_VAL`==0).
- Sweep length: `busy` stays high for 2^ADDR_W cycles after `reset` falls (16 at defaults). The first IDLE edge accepts ops.
- Read latency: 1 cycle. `addr` presented at edge N gives `q` valid after edge N.
- Read-during-write to the same address: `q` shows the new value after the edge (write-first).
- `inc`/`dec` read-modify-write completes in one cycle. Back-to-back ops on the same address are allowed every cycle with no hazard.
- `sat` is high for exactly the cycle after the saturating op.
- `reset` mid-sweep restarts the sweep from `ptr`=0.

## Structure
- Shared package `astro_pkg` holds:
  - `SHOT_SLOTS_W` = 4
  - `SHOT_LOAD_W` = 2
  - `SHOT_LOAD_FULL` = 2'b10
  - state enum `{IDLE, SWEEP}`
- Sub-module `init_sweeper`:
  - holds the FSM, `ptr` counter and `busy` flag;
  - outputs `sweep_we` and `sweep_addr`, which the top muxes onto the RAM write port.
- The top holds the array, op priority, saturation logic and `addr_reg`.

## Test plan
1. Reset sweep: assert `reset` 3 cycles, release → `busy`=1 for 16 cycles. Then reading every address 0..15 gives `q`=2'b10.
2. Write/read: `we`, `addr`=5, `data`=2'b01 → next cycle `q`=01, `zero`=0. Read `addr`=6 → `q`=10.
3. Decrement saturation: `addr`=3 starts at 10; `dec` three consecutive cycles → `q`=01, then 00, then 00. `sat` pulses only after the third, and `zero`=1.
4. Increment saturation and priority:
   - `inc` at `addr`=3 holding 11 → `q`=11 and `sat` pulses.
   - `we`+`dec` together with `data`=00 → `q`=00 (the write wins).
5. Ops during busy: pulse `init`, then assert `we` `addr`=2 `data`=00 during the sweep → ignored. After `busy` falls, `ram[2]`=10 and no `sat`.
6. Reset mid-operation: `reset` at sweep `ptr`=9 → sweep restarts and `busy` lasts 16 more cycles. All entries end at 10.

Source files
------------

// File: rtl/astro_pkg.sv
// Shared AstroGenius datapath constants and the init-sweep state type.
package astro_pkg;

    localparam int SHOT_SLOTS_W = 4;
    localparam int SHOT_LOAD_W  = 2;
    localparam logic [SHOT_LOAD_W-1:0] SHOT_LOAD_FULL = 2'b10;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } sweep_state_t;

endpackage

// File: rtl/init_sweeper.sv
// Walks a pointer across every RAM address once, one per cycle, after reset or init.
module init_sweeper
    import astro_pkg::*;
#(
    parameter int ADDR_W = SHOT_SLOTS_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    output logic              busy,
    output logic              sweep_we,
    output logic [ADDR_W-1:0] sweep_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    sweep_state_t      r_state;
    sweep_state_t      w_state_next;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] w_ptr_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= SWEEP;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_next;
            r_ptr   <= w_ptr_next;
        end
    end

    // The pointer parks on the top address when the sweep ends; it never wraps.
    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        case (r_state)
            IDLE: begin
                if (init) begin
                    w_state_next = SWEEP;
                    w_ptr_next   = '0;
                end
            end
            SWEEP: begin
                if (r_ptr == LAST_ADDR) begin
                    w_state_next = IDLE;
                end else begin
                    w_ptr_next = r_ptr + 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign busy       = (r_state == SWEEP);
    assign sweep_we   = busy;
    assign sweep_addr = r_ptr;

endmodule

// File: rtl/shot_load_ram.sv
// Per-slot shot load counters with direct write, saturating inc/dec and a swept init.
module shot_load_ram
    import astro_pkg::*;
#(
    parameter int                 DATA_W   = SHOT_LOAD_W,
    parameter int                 ADDR_W   = SHOT_SLOTS_W,
    parameter logic [DATA_W-1:0]  INIT_VAL = SHOT_LOAD_FULL,
    parameter logic [DATA_W-1:0]  MAX_VAL  = {DATA_W{1'b1}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    input  logic              we,
    input  logic              inc,
    input  logic              dec,
    input  logic [DATA_W-1:0] data,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] q,
    output logic              zero,
    output logic              busy,
    output logic              sat
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [DATA_W:0] ONE_EXT = {{DATA_W{1'b0}}, 1'b1};

    logic [DATA_W-1:0] r_ram [DEPTH];
    logic [ADDR_W-1:0] r_addr;
    logic              r_sat;

    logic              w_busy;
    logic              w_sweep_we;
    logic [ADDR_W-1:0] w_sweep_addr;
    logic              w_ops_ok;
    logic [DATA_W-1:0] w_rd;
    logic [DATA_W:0]   w_inc_ext;
    logic [DATA_W:0]   w_dec_ext;
    logic              w_op_en;
    logic [DATA_W-1:0] w_op_val;
    logic              w_sat_hit;
    logic              w_wr_en;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [DATA_W-1:0] w_wr_data;

    init_sweeper #(
        .ADDR_W (ADDR_W)
    ) u_sweeper (
        .clk        (clk),
        .reset      (reset),
        .init       (init),
        .busy       (w_busy),
        .sweep_we   (w_sweep_we),
        .sweep_addr (w_sweep_addr)
    );

    assign w_ops_ok  = !w_busy && !reset;
    assign w_rd      = r_ram[addr];
    assign w_inc_ext = {1'b0, w_rd} + ONE_EXT;
    assign w_dec_ext = {1'b0, w_rd} - ONE_EXT;

    // Write wins over dec, dec over inc; a saturating op leaves the entry untouched.
    always_comb begin
        w_op_en   = 1'b0;
        w_op_val  = w_rd;
        w_sat_hit = 1'b0;
        if (w_ops_ok) begin
            if (we) begin
                w_op_en  = 1'b1;
                w_op_val = data;
            end else if (dec) begin
                w_op_en = 1'b1;
                if (w_rd == '0) begin
                    w_sat_hit = 1'b1;
                end else begin
                    w_op_val = w_dec_ext[DATA_W-1:0];
                end
            end else if (inc) begin
                w_op_en = 1'b1;
                if (w_rd == MAX_VAL) begin
                    w_sat_hit = 1'b1;
                end else begin
                    w_op_val = w_inc_ext[DATA_W-1:0];
                end
            end
        end
    end

    assign w_wr_en   = w_sweep_we || w_op_en;
    assign w_wr_addr = w_sweep_we ? w_sweep_addr : addr;
    assign w_wr_data = w_sweep_we ? INIT_VAL : w_op_val;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_ram[w_wr_addr] <= w_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr <= '0;
            r_sat  <= 1'b0;
        end else begin
            if (!w_busy) begin
                r_addr <= addr;
            end
            r_sat <= w_sat_hit;
        end
    end

    // Contents are only trustworthy once the sweep is done, so reads show INIT_VAL meanwhile.
    assign q    = w_busy ? INIT_VAL : r_ram[r_addr];
    assign zero = (q == '0);
    assign busy = w_busy;
    assign sat  = r_sat;

endmodule
